// File: rtl/uart_alu_engine.sv
// Byte-stream packet engine: parses framed echo/add/mul/div commands from rx, returns results on tx.
// Results are DATA_W/8 bytes, least-significant byte first; ready/valid on both byte interfaces.
module uart_alu_engine #(
  parameter int DATA_W = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int          BYTES    = DATA_W / 8;
  localparam logic [3:0]  LAST_B   = 4'(BYTES - 1);
  localparam logic [15:0] BYTES16  = 16'(BYTES);
  localparam logic [15:0] DIV_PAY  = 16'(2 * BYTES);
  localparam logic [6:0]  DIV_LAST = 7'(DATA_W - 1);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  typedef enum logic [3:0] {
    S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_DIV, S_SEND, S_ECHO, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          opc_q, opc_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [3:0]          bidx_q, bidx_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [6:0]          dcnt_q, dcnt_d;
  logic                err_q, err_d;

  logic [15:0]         len_full, pay_len;
  logic                len_short, hdr_ok, rx_fire, tx_fire, div_ge;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W:0]     rem_sh;

  assign len_full  = {rx_data_i, len_lo_q};
  assign pay_len   = len_full - 16'd4;
  assign len_short = len_full < 16'd4;

  // Operand as it will look once the current rx byte lands in its little-endian slot.
  always_comb begin
    opnd = shreg_q;
    opnd[{bidx_q, 3'b000} +: 8] = rx_data_i;
  end

  // Restoring divider: quotient bits shift into acc_q as dividend bits shift out of it.
  assign rem_sh = {rem_q, acc_q[DATA_W-1]};
  assign div_ge = rem_sh >= {1'b0, dvs_q};

  always_comb begin
    hdr_ok = 1'b0;
    if (!len_short) begin
      case (opc_q)
        OP_ECHO:        hdr_ok = 1'b1;
        OP_ADD, OP_MUL: hdr_ok = ((pay_len % BYTES16) == 16'd0) && (pay_len != 16'd0);
        OP_DIV:         hdr_ok = pay_len == DIV_PAY;
        default:        hdr_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    rx_ready_o = 1'b1;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    state_d    = state_q;
    opc_d      = opc_q;
    len_lo_d   = len_lo_q;
    cnt_d      = cnt_q;
    bidx_d     = bidx_q;
    first_d    = first_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    dcnt_d     = dcnt_q;
    err_d      = 1'b0;

    case (state_q)
      S_DIV:  rx_ready_o = 1'b0;
      S_SEND: begin
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b1;
        tx_data_o  = acc_q[7:0];
      end
      S_ECHO: begin
        rx_ready_o = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
      default: ;
    endcase

    rx_fire = rx_valid_i & rx_ready_o;
    tx_fire = tx_valid_o & tx_ready_i;

    case (state_q)
      S_OPCODE: if (rx_fire) begin
        opc_d   = rx_data_i;
        state_d = S_RSVD;
      end
      S_RSVD: if (rx_fire) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_fire) begin
        len_lo_d = rx_data_i;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (rx_fire) begin
        cnt_d   = len_short ? 16'd0 : pay_len;
        bidx_d  = 4'd0;
        first_d = 1'b1;
        shreg_d = '0;
        acc_d   = '0;
        err_d   = ~hdr_ok;
        if (len_short || pay_len == 16'd0) state_d = S_OPCODE;
        else if (!hdr_ok)                  state_d = S_DRAIN;
        else if (opc_q == OP_ECHO)         state_d = S_ECHO;
        else                               state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (rx_fire) begin
        cnt_d = cnt_q - 16'd1;
        if (bidx_q == LAST_B) begin
          bidx_d  = 4'd0;
          shreg_d = '0;
          first_d = 1'b0;
          if (first_q)              acc_d = opnd;
          else if (opc_q == OP_ADD) acc_d = acc_q + opnd;
          else if (opc_q == OP_MUL) acc_d = acc_q * opnd;
          else                      dvs_d = opnd;
        end else begin
          bidx_d  = bidx_q + 4'd1;
          shreg_d = opnd;
        end
        if (cnt_q == 16'd1) begin
          state_d = (opc_q == OP_DIV) ? S_DIV : S_SEND;
          rem_d   = '0;
          dcnt_d  = 7'd0;
        end
      end
      S_DIV: begin
        rem_d  = div_ge ? (rem_sh[DATA_W-1:0] - dvs_q) : rem_sh[DATA_W-1:0];
        acc_d  = {acc_q[DATA_W-2:0], div_ge};
        dcnt_d = dcnt_q + 7'd1;
        if (dcnt_q == DIV_LAST) state_d = S_SEND;
      end
      S_SEND: if (tx_fire) begin
        acc_d = acc_q >> 8;
        if (bidx_q == LAST_B) begin
          bidx_d  = 4'd0;
          state_d = S_OPCODE;
        end else begin
          bidx_d = bidx_q + 4'd1;
        end
      end
      S_ECHO, S_DRAIN: if (rx_fire) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_OPCODE;
      end
      default: state_d = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_OPCODE;
      opc_q    <= 8'h00;
      len_lo_q <= 8'h00;
      cnt_q    <= 16'd0;
      bidx_q   <= 4'd0;
      first_q  <= 1'b0;
      shreg_q  <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      dcnt_q   <= 7'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      bidx_q   <= bidx_d;
      first_q  <= first_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      dcnt_q   <= dcnt_d;
      err_q    <= err_d;
    end
  end

  assign busy_o = state_q != S_OPCODE;
  assign err_o  = err_q;

endmodule

// File: tb/tb_uart_alu_engine.sv
// Testbench for uart_alu_engine: table vectors, hand-written reset/stall/latency sequences,
// and randomized packets checked against a byte-level reference model.
module tb_uart_alu_engine;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       err_o;

  logic [7:0] r16_data;
  logic       r16_valid, r16_ready;
  logic [7:0] t16_data;
  logic       t16_valid;
  logic       t16_ready;
  logic       busy16, err16;

  uart_alu_engine #(.DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  uart_alu_engine #(.DATA_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst_i),
    .rx_data_i(r16_data), .rx_valid_i(r16_valid), .rx_ready_o(r16_ready),
    .tx_data_o(t16_data), .tx_valid_o(t16_valid), .tx_ready_i(t16_ready),
    .busy_o(busy16), .err_o(err16)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_n, err_cyc, hdr_n, lenhi_cyc, last_rx_cyc, first_tv_cyc;
  bit tv_seen;
  int tx_mode = 0;
  int rx_gap_max = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  t16_q[$];
  logic [7:0]  pkt[$];
  logic [7:0]  exp_q[$];
  bit          exp_err;
  logic [31:0] wv[5];

  typedef struct {
    logic [7:0]  opc;
    int          len;
    logic [31:0] w0, w1, w2;
    logic [31:0] res;
    int          ntx;
    bit          err;
    int          txm;
  } vec_t;

  vec_t tv[17];

  function automatic void chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endfunction

  // Observation at the falling edge: values here are what the next rising edge will sample.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rx_valid_i && rx_ready_o) begin
      hdr_n++;
      last_rx_cyc = cyc;
      if (hdr_n == 4) lenhi_cyc = cyc;
    end
    if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
    if (tx_valid_o && !tv_seen) begin
      tv_seen = 1'b1;
      first_tv_cyc = cyc;
    end
    if (err_o) begin
      err_n++;
      err_cyc = cyc;
    end
    if (t16_valid && t16_ready) t16_q.push_back(t16_data);
  end

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0: tx_ready_i = 1'b1;
        1: tx_ready_i = ~tx_ready_i;
        2: tx_ready_i = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic clear_obs();
    tx_q.delete();
    err_n = 0;
    hdr_n = 0;
    tv_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, rx_gap_max)) begin @(posedge clk); #1; end
    rx_data_i = b;
    rx_valid_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rx_ready_o && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL rx handshake: rx_ready_o low for %0d cycles, limit 2000", t);
    end
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int ntx);
    int t = 0;
    while ((tx_q.size() < ntx || busy_o) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL completion: %0d of %0d bytes after %0d cycles", tx_q.size(), ntx, t);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [7:0] opc, input int len);
    pkt.delete();
    pkt.push_back(opc);
    pkt.push_back(8'($urandom_range(0, 255)));
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
    for (int j = 0; j < len - 4; j++) pkt.push_back(wv[j/4][8*(j%4) +: 8]);
  endtask

  task automatic run_pkt();
    clear_obs();
    foreach (pkt[i]) send_byte(pkt[i]);
    wait_done(exp_q.size());
  endtask

  // Reference: packet rules evaluated on whole operands with plain integer arithmetic.
  task automatic model();
    int len, pl, n;
    logic [31:0] op[5];
    longint unsigned r;
    longint unsigned mask;
    mask = 64'hFFFF_FFFF;
    len = int'(pkt[2]) + 256 * int'(pkt[3]);
    pl = len - 4;
    exp_q.delete();
    exp_err = 1'b0;
    if (len < 4) begin exp_err = 1'b1; return; end
    if (pkt[0] == 8'hEC) begin
      for (int i = 0; i < pl; i++) exp_q.push_back(pkt[4+i]);
      return;
    end
    if (!(pkt[0] inside {8'hA0, 8'hA1, 8'hA2}) || (pl % 4) != 0) begin exp_err = 1'b1; return; end
    n = pl / 4;
    if ((pkt[0] != 8'hA2 && n == 0) || (pkt[0] == 8'hA2 && n != 2)) begin exp_err = 1'b1; return; end
    for (int k = 0; k < n; k++) op[k] = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
    if (pkt[0] == 8'hA0) begin
      r = 0;
      for (int k = 0; k < n; k++) r = (r + op[k]) & mask;
    end else if (pkt[0] == 8'hA1) begin
      r = op[0];
      for (int k = 1; k < n; k++) r = (r * op[k]) & mask;
    end else begin
      r = (op[1] == 0) ? mask : longint'(op[0] / op[1]);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(r >> (8*i)));
  endtask

  task automatic cmp(input string nm);
    chk({nm, " tx count"}, tx_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < tx_q.size()) chk($sformatf("%s byte%0d", nm, i), tx_q[i], exp_q[i]);
    chk({nm, " err pulses"}, err_n, exp_err ? 1 : 0);
    if (exp_err) chk({nm, " err timing"}, err_cyc - lenhi_cyc, 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " rx_ready"}, rx_ready_o, 1);
    chk({nm, " tx_valid"}, tx_valid_o, 0);
    chk({nm, " tx_data"}, tx_data_o, 0);
    chk({nm, " busy"}, busy_o, 0);
    chk({nm, " err"}, err_o, 0);
  endtask

  task automatic send16(input logic [7:0] b);
    int t = 0;
    r16_data = b;
    r16_valid = 1'b1;
    @(negedge clk);
    while (!r16_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL w16 handshake: rx_ready_o low for %0d cycles", t);
    end
    @(posedge clk); #1;
    r16_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] b16[8];
    int t;
    tv[0]  = '{8'hEC,  8, 32'd5,        32'd0, 32'd0, 32'd5,         4, 1'b0, 1};
    tv[1]  = '{8'hA0, 12, 32'd5,        32'd7, 32'd0, 32'h0000000C,  4, 1'b0, 0};
    tv[2]  = '{8'hA0, 16, 32'd1,        32'd2, 32'd3, 32'h00000006,  4, 1'b0, 0};
    tv[3]  = '{8'hA0, 12, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h00000001,  4, 1'b0, 2};
    tv[4]  = '{8'hA1, 12, 32'd3,        32'd4, 32'd0, 32'h0000000C,  4, 1'b0, 0};
    tv[5]  = '{8'hA2, 12, 32'd15,       32'd3, 32'd0, 32'h00000005,  4, 1'b0, 0};
    tv[6]  = '{8'hA2, 12, 32'd7,        32'd0, 32'd0, 32'hFFFFFFFF,  4, 1'b0, 0};
    tv[7]  = '{8'h55,  8, 32'h11223344, 32'd0, 32'd0, 32'd0,         0, 1'b1, 0};
    tv[8]  = '{8'hA0, 12, 32'd10,       32'd20,32'd0, 32'h0000001E,  4, 1'b0, 0};
    tv[9]  = '{8'hA2, 16, 32'd9,        32'd3, 32'd1, 32'd0,         0, 1'b1, 0};
    tv[10] = '{8'hA0, 12, 32'h100,      32'h23,32'd0, 32'h00000123,  4, 1'b0, 0};
    tv[11] = '{8'hA0,  6, 32'hBEEF,     32'd0, 32'd0, 32'd0,         0, 1'b1, 0};
    tv[12] = '{8'hA0, 12, 32'd40,       32'd2, 32'd0, 32'h0000002A,  4, 1'b0, 0};
    tv[13] = '{8'hA1, 16, 32'h10000,    32'h10000, 32'd7, 32'h00000000, 4, 1'b0, 0};
    tv[14] = '{8'hEC,  4, 32'd0,        32'd0, 32'd0, 32'd0,         0, 1'b0, 0};
    tv[15] = '{8'hA0,  4, 32'd0,        32'd0, 32'd0, 32'd0,         0, 1'b1, 0};
    tv[16] = '{8'hA1,  2, 32'd0,        32'd0, 32'd0, 32'd0,         0, 1'b1, 0};

    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    r16_valid = 1'b0;
    r16_data = 8'h00;
    t16_ready = 1'b1;
    clear_obs();
    repeat (3) @(negedge clk);
    chk_reset_outs("in reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_reset_outs("after reset");
    @(posedge clk); #1;

    b16 = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h34, 8'h12, 8'h01, 8'h00};
    foreach (b16[i]) send16(b16[i]);
    t = 0;
    while (t16_q.size() < 2 && t < 200) begin @(negedge clk); t++; end
    chk("w16 tx count", t16_q.size(), 2);
    if (t16_q.size() >= 2) begin
      chk("w16 byte0", t16_q[0], 8'h35);
      chk("w16 byte1", t16_q[1], 8'h12);
    end
    @(posedge clk); #1;

    foreach (tv[v]) begin
      tx_mode = tv[v].txm;
      wv[0] = tv[v].w0; wv[1] = tv[v].w1; wv[2] = tv[v].w2; wv[3] = '0; wv[4] = '0;
      build(tv[v].opc, tv[v].len);
      exp_q.delete();
      for (int i = 0; i < tv[v].ntx; i++) exp_q.push_back(tv[v].res[8*i +: 8]);
      exp_err = tv[v].err;
      run_pkt();
      cmp($sformatf("vec%0d", v));
      if (!tv[v].err && tv[v].opc inside {8'hA0, 8'hA1})
        chk($sformatf("vec%0d send latency", v), first_tv_cyc - last_rx_cyc, 1);
      if (!tv[v].err && tv[v].opc == 8'hA2)
        chk($sformatf("vec%0d div latency", v), first_tv_cyc - last_rx_cyc, 33);
    end
    tx_mode = 0;

    // Reset mid-payload, then mid-SEND with tx stalled, then a clean multiply.
    wv[0] = 32'd2; wv[1] = 32'd9;
    build(8'hA1, 12);
    clear_obs();
    for (int i = 0; i < 6; i++) send_byte(pkt[i]);
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst mid-payload");
    @(posedge clk); #1;
    rst_i = 1'b0;

    tx_mode = 3;
    tx_ready_i = 1'b0;
    wv[0] = 32'd5; wv[1] = 32'd7;
    build(8'hA0, 12);
    clear_obs();
    foreach (pkt[i]) send_byte(pkt[i]);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("stall tx_valid", tx_valid_o, 1);
    chk("stall tx_data", tx_data_o, 8'h0C);
    chk("stall no transfer", tx_q.size(), 0);
    @(posedge clk); #1;
    tx_ready_i = 1'b1;
    @(posedge clk); #1;
    tx_ready_i = 1'b0;
    @(negedge clk);
    chk("stall next byte", tx_data_o, 8'h00);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst mid-send sent", tx_q.size(), 1);
    if (tx_q.size() > 0) chk("rst mid-send byte0", tx_q[0], 8'h0C);
    chk_reset_outs("rst mid-send");
    @(posedge clk); #1;
    rst_i = 1'b0;
    tx_mode = 0;

    wv[0] = 32'd2; wv[1] = 32'd9;
    build(8'hA1, 12);
    exp_q = '{8'h12, 8'h00, 8'h00, 8'h00};
    exp_err = 1'b0;
    run_pkt();
    cmp("post-reset mul");

    for (int p = 0; p < 45; p++) begin
      int kind, n, len;
      logic [7:0] opc;
      kind = $urandom_range(0, 5);
      for (int i = 0; i < 5; i++) wv[i] = $urandom;
      case (kind)
        0: begin opc = 8'hEC; len = $urandom_range(4, 12); end
        1: begin opc = 8'hA0; n = $urandom_range(1, 4); len = 4 + 4*n; end
        2: begin opc = 8'hA1; n = $urandom_range(1, 3); len = 4 + 4*n;
                 for (int i = 0; i < 3; i++) if ($urandom_range(0, 1) == 1) wv[i] = $urandom_range(0, 300); end
        3: begin opc = 8'hA2; len = 12;
                 if ($urandom_range(0, 3) == 0) wv[1] = 0;
                 else if ($urandom_range(0, 1) == 1) wv[1] = $urandom_range(1, 50); end
        4: begin opc = 8'($urandom_range(0, 255)); len = $urandom_range(4, 10); end
        default: begin opc = 8'($urandom_range(8'hA0, 8'hA2)); len = $urandom_range(0, 14); end
      endcase
      tx_mode = $urandom_range(0, 2);
      rx_gap_max = $urandom_range(0, 2);
      build(opc, len);
      model();
      run_pkt();
      cmp($sformatf("rand%0d op%02h len%0d", p, opc, len));
    end
    tx_mode = 0;
    rx_gap_max = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
